// File: rtl/muldiv_ctrl.sv
// Iterative signed 32-bit multiply / restoring-divide sequencer with a ready pulse.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero completes one cycle after start.
module muldiv_ctrl #(
   parameter int unsigned ITERS = 32,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_mult,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] work_q;
   logic [WIDTH-1:0]   op_q;
   logic [4:0]         cnt_q;
   logic               neg_q, dz_q, ovf_q;
   logic [WIDTH-1:0]   result_q;
   logic               exc_q, rdy_q, busy_q;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] mul_d, div_shift, div_d, product;
   logic [WIDTH-1:0]   quot;
   logic               mul_ovf, last;

   always_comb begin
      mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
      mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
      last  = (cnt_q == 5'(ITERS - 1));
      // Shift-add: low half holds the multiplier, high half accumulates; carry shifts in.
      mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, op_q};
      if (work_q[0])
         mul_d = {mul_sum, work_q[WIDTH-1:1]};
      else
         mul_d = {1'b0, work_q[2*WIDTH-1:1]};
      div_shift = {work_q[2*WIDTH-2:0], 1'b0};
      div_diff  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, op_q};
      if (div_diff[WIDTH])
         div_d = div_shift;
      else
         div_d = {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
      product = neg_q ? -mul_d : mul_d;
      quot    = neg_q ? -div_d[WIDTH-1:0] : div_d[WIDTH-1:0];
      mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         work_q   <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               rdy_q <= 1'b0;
               cnt_q <= '0;
               neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
               if (ctrl_mult) begin
                  state_q <= MULT;
                  busy_q  <= 1'b1;
                  work_q  <= {{WIDTH{1'b0}}, mag_b};
                  op_q    <= mag_a;
               end else if (ctrl_div) begin
                  work_q <= {{WIDTH{1'b0}}, mag_a};
                  op_q   <= mag_b;
                  dz_q   <= (operand_b == '0);
                  ovf_q  <= (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
`ifdef MULDIV_DIV0_FAST_EN
                  if (operand_b == '0) begin
                     state_q  <= DONE;
                     result_q <= '0;
                     exc_q    <= 1'b1;
                     rdy_q    <= 1'b1;
                  end else begin
                     state_q <= DIV;
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= DIV;
                  busy_q  <= 1'b1;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            MULT: begin
               cnt_q  <= cnt_q + 5'd1;
               work_q <= mul_d;
               if (last) begin
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  rdy_q    <= 1'b1;
                  result_q <= product[WIDTH-1:0];
                  exc_q    <= mul_ovf;
               end
            end
            DIV: begin
               cnt_q  <= cnt_q + 5'd1;
               work_q <= div_d;
               if (last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  if (dz_q) begin
                     result_q <= '0;
                     exc_q    <= 1'b1;
                  end else begin
                     result_q <= quot;
                     exc_q    <= ovf_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result     = result_q;
   assign exception  = exc_q;
   assign result_rdy = rdy_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expectations queued at launch, checked at result_rdy.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ctrl_mult, ctrl_div;
   logic [31:0] operand_a, operand_b;
   logic [31:0] result;
   logic        exception, result_rdy, busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          lat;
      int          bcyc;
   } exp_t;
   exp_t sb[$];

`ifdef MULDIV_DIV0_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   always #5 clk = ~clk;

   muldiv_ctrl #(.ITERS(32), .WIDTH(32)) dut (
      .clk(clk), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
      .operand_a(operand_a), .operand_b(operand_b), .result(result),
      .exception(exception), .result_rdy(result_rdy), .busy(busy)
   );

   function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint p;
      int     sa, sbv;
      e.lat  = 33;
      e.bcyc = 32;
      if (m) begin
         p     = longint'($signed(a)) * longint'($signed(b));
         e.res = p[31:0];
         e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
         if (FAST) begin
            e.lat  = 1;
            e.bcyc = 0;
         end
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else begin
         sa    = a;
         sbv   = b;
         e.res = sa / sbv;
         e.exc = 1'b0;
      end
      return e;
   endfunction

   // Caller is mid-cycle; inputs are sampled on the next rising edge.
   task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input bit ee, input int lat, input int bcyc);
      exp_t e;
      e.res = er; e.exc = ee; e.lat = lat; e.bcyc = bcyc;
      sb.push_back(e);
      ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b;
   endtask

   task automatic launch_model(input bit m, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e = model(m, a, b);
      launch(m, !m, a, b, e.res, e.exc, e.lat, e.bcyc);
   endtask

   task automatic collect(input string name, input int repulse_at);
      exp_t e;
      int   lat, bc;
      @(posedge clk); #1;
      ctrl_mult = 1'b0; ctrl_div = 1'b0;
      lat = 1; bc = 0;
      while (!result_rdy && lat <= 100) begin
         if (busy) bc++;
         if (lat == repulse_at) ctrl_div = 1'b1;
         @(posedge clk); #1;
         ctrl_div = 1'b0;
         lat++;
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got empty queue, required one entry", name);
         return;
      end
      e = sb.pop_front();
      if (lat > 100) begin
         errors++;
         $display("FAIL %s timeout: got no result_rdy in 100 cycles, required latency %0d", name, e.lat);
         return;
      end
      if (lat !== e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
      end
      checks++;
      if (result !== e.res) begin
         errors++;
         $display("FAIL %s result: got %h required %h", name, result, e.res);
      end
      checks++;
      if (exception !== e.exc) begin
         errors++;
         $display("FAIL %s exception: got %b required %b", name, exception, e.exc);
      end
      checks++;
      if (bc !== e.bcyc || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: got %0d cycles (busy=%b at rdy) required %0d cycles", name, bc, busy, e.bcyc);
      end
   endtask

   task automatic check_pulse_end(input string name);
      @(posedge clk); #1;
      checks++;
      if (result_rdy !== 1'b0) begin
         errors++;
         $display("FAIL %s rdy_width: got rdy=%b one cycle later, required 0", name, result_rdy);
      end
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      int hits;
      hits = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (result_rdy || busy) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL %s quiet: got %0d cycles with rdy/busy, required 0", name, hits);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({result, exception, result_rdy, busy} !== 35'd0) begin
         errors++;
         $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b required all 0",
                  result, exception, result_rdy, busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_mult();
      launch(1, 0, 32'd7, -32'sd6, 32'hFFFF_FFD6, 0, 33, 32);
      collect("mult_7x-6", -1);
      check_pulse_end("mult_7x-6");
      launch(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 33, 32);
      collect("mult_ovf", -1);
      check_pulse_end("mult_ovf");
      launch(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 33, 32);
      collect("mult_m1xm1", -1);
      check_pulse_end("mult_m1xm1");
   endtask

   task automatic test_div();
      launch(0, 1, -32'sd17, 32'd5, 32'hFFFF_FFFD, 0, 33, 32);
      collect("div_-17/5", -1);
      check_pulse_end("div_-17/5");
      launch(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33, 32);
      collect("div_min/-1", -1);
      check_pulse_end("div_min/-1");
      launch(0, 1, 32'd1234, 32'd0, 32'h0, 1, FAST ? 1 : 33, FAST ? 0 : 32);
      collect("div_by_zero", -1);
      check_pulse_end("div_by_zero");
   endtask

   task automatic test_priority_and_repulse();
      launch(1, 1, 32'd6, 32'd3, 32'd18, 0, 33, 32);
      collect("both_start", -1);
      check_pulse_end("both_start");
      launch(0, 1, 32'd100, 32'd7, 32'd14, 0, 33, 32);
      collect("div_repulse", 10);
      watch_quiet("div_repulse", 40);
   endtask

   task automatic test_reset_mid();
      ctrl_mult = 1'b1; operand_a = 32'd123; operand_b = 32'd456;
      @(posedge clk); #1;
      ctrl_mult = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (result !== 32'd0 || busy !== 1'b0 || result_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got res=%h busy=%b rdy=%b required 0/0/0", result, busy, result_rdy);
      end
      watch_quiet("reset_mid", 40);
   endtask

   task automatic test_back_to_back();
      launch(1, 0, 32'd1000, 32'd1000, 32'd1000000, 0, 33, 32);
      collect("b2b_first", -1);
      launch(0, 1, -32'sd1000, 32'd7, -32'sd142, 0, 33, 32);
      collect("b2b_second", -1);
      check_pulse_end("b2b_second");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      bit m;
      for (int i = 0; i < 8; i++) begin
         m = (i % 2) == 0;
         a = $urandom;
         b = (i % 4 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
         if (i % 4 == 2) a = 32'($urandom_range(0, 70000));
         launch_model(m, a, b);
         collect(m ? "rand_mult" : "rand_div", -1);
         check_pulse_end(m ? "rand_mult" : "rand_div");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_priority_and_repulse();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative signed 32-bit multiply/divide sequencer for the processor execute stage. It latches operands on a start pulse and runs a 32-iteration shift-add multiply or restoring divide over an internal 64-bit working register, stepping a 5-bit iteration counter. It returns a one-cycle ready pulse with the result and exception flag, and the pipeline stalls on busy.

Parameters:
ITERS, 32, iteration count; fixed at the operand width, 5-bit counter wraps 31->0 to end
WIDTH, 32, operand/result width; only 32 supported

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; sampled on rising clk edge
ctrl_mult  input  1  start-multiply pulse; sampled in IDLE/DONE only
ctrl_div  input  1  start-divide pulse; sampled in IDLE/DONE only
operand_a  input  32  multiplicand / dividend (two's complement), captured at start
operand_b  input  32  multiplier / divisor (two's complement), captured at start
result  output  32  low 32 bits of product, or quotient
exception  output  1  overflow / divide-by-zero flag, valid with result
result_rdy  output  1  one-cycle completion pulse
busy  output  1  high from the cycle after start through the final iteration

Behaviour:
- States: IDLE, MULT, DIV, DONE. Reset (sync) forces IDLE; result=0, exception=0, result_rdy=0, busy=0, counter=0.
- Start: edge k with state IDLE or DONE and ctrl_mult=1 -> MULT; else ctrl_div=1 -> DIV. Both high: multiply wins, divide dropped. Operands captured at edge k.
- ctrl_mult/ctrl_div while in MULT/DIV are ignored; no queueing.
- Iterations on edges k+1..k+32; counter increments each iteration, wraps 31->0 on the last one, and then the state goes DONE.
- DONE is held for exactly the cycle after edge k+32: result_rdy=1, busy=0. Next edge: back to IDLE unless a new start is sampled (back-to-back allowed, DONE->MULT/DIV directly).
- result/exception update only on entry to DONE and hold until the next DONE or reset. Latency start-edge to rdy: 33 cycles.
- Multiply: magnitudes multiplied unsigned, sign = a[31]^b[31], 64-bit product negated if needed. result = product[31:0]. exception=1 iff product[63:31] is not all-equal (true signed overflow).
- Divide: restoring on magnitudes, quotient truncates toward zero, sign applied at the end; remainder discarded.
- b==0: result=0, exception=1. a=0x80000000 and b=0xFFFFFFFF: result=0x80000000, exception=1.
- Reset mid-operation: immediate IDLE on that edge, no result_rdy pulse for the aborted op, and result clears to 0.
- busy=1 in MULT and DIV only.

Optional Feature:
MULDIV_DIV0_FAST_EN
- Defined: a divide start with operand_b==0 goes directly to DONE on edge k. result_rdy fires in cycle k+1 (1-cycle latency) with result=0, exception=1, and busy never asserts.
- Undefined: divide-by-zero takes the full 33-cycle latency with the same result and exception values.

Test Plan:
- Reset, then pulse ctrl_mult with a=7, b=-6 -> result_rdy exactly 33 cycles later for 1 cycle; result=0xFFFFFFD6, exception=0; busy high 32 cycles.
- ctrl_div with a=-17, b=5 -> result=0xFFFFFFFD (-3), exception=0; then a=0x80000000, b=-1 -> result=0x80000000, exception=1.
- ctrl_mult with a=0x00010000, b=0x00010000 -> result=0, exception=1. With a=0xFFFFFFFF, b=0xFFFFFFFF -> result=1, exception=0.
- ctrl_div with b=0 -> result=0, exception=1. Latency is 33 cycles without MULDIV_DIV0_FAST_EN and 1 cycle with it.
- Simultaneous ctrl_mult and ctrl_div with a=6, b=3 -> result=18, not 2. Re-pulse ctrl_div at cycle 10 of the op -> ignored, exactly one rdy pulse.
- Assert reset at cycle 15 of a multiply -> no rdy pulse, result=0, busy=0 next cycle. Then a start in the DONE cycle of a following op -> back-to-back 33-cycle completion.
